// File: rtl/pos_scan_pkg.sv
// pos_scan_pkg: shared state encoding and sizes for the truth-table scanner
package pos_scan_pkg;
  localparam int N_COMB = 16;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/lsb_pick16.sv
// lsb_pick16: lowest-set-bit index, any and exactly-one-set flags of a 16-bit mask
module lsb_pick16
  import pos_scan_pkg::*;
(
  input  logic [N_COMB-1:0] i_mask,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any,
  output logic              o_one_hot
);
  always_comb begin
    o_idx = '0;
    for (int i = N_COMB - 1; i >= 0; i--) if (i_mask[i]) o_idx = IDX_W'(i);
  end
  assign o_any = |i_mask;
  assign o_one_hot = o_any && ((i_mask & (i_mask - N_COMB'(1))) == '0);
endmodule

// File: rtl/pos_term_scanner.sv
// pos_term_scanner: reads a 4-input block's truth table and streams its maxterm indices
module pos_term_scanner
  import pos_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  drv_abcd,
  input  logic              f_in,
  output logic              busy,
  output logic              done,
  output logic [N_COMB-1:0] table_out,
  output logic [4:0]        zero_cnt,
  output logic              term_valid,
  input  logic              term_ready,
  output logic [IDX_W-1:0]  term_idx,
  output logic              term_last
);
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [3:0] r_cnt;
  logic [N_COMB-1:0] r_table, r_pending;
  logic [4:0] r_zero;
  logic w_any, w_one, w_samp, w_hs;
  lsb_pick16 u_pick (.i_mask(r_pending), .o_idx(w_idx), .o_any(w_any), .o_one_hot(w_one));
  assign w_samp = r_cnt == 4'(SETTLE - 1);
  assign w_hs = w_any & term_ready;
  assign drv_abcd = (r_state == IDLE) ? '0 : r_idx;
  assign busy = (r_state == SCAN) || (r_state == EMIT);
  assign done = r_state == DONE;
  assign table_out = r_table;
  assign zero_cnt = r_zero;
  assign term_valid = w_any;
  assign term_idx = w_idx;
  assign term_last = w_one;
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? SCAN : IDLE) :
             (r_state == SCAN) ? ((w_samp && r_idx == '1) ? EMIT : SCAN) :
             (r_state == EMIT) ? ((!w_any || (w_hs && w_one)) ? DONE : EMIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_table <= '0;
      r_zero <= '0;
      r_pending <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_idx <= '0;
        r_cnt <= '0;
        r_table <= '0;
        r_zero <= '0;
      end
      if (r_state == SCAN) begin
        r_cnt <= w_samp ? '0 : r_cnt + 4'd1;
        if (w_samp) begin
          r_table[r_idx] <= f_in;
          r_zero <= r_zero + {4'd0, ~f_in};
          if (r_idx == '1) r_pending <= ~{f_in, r_table[N_COMB-2:0]};
          else r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (r_state == EMIT && w_hs) r_pending <= r_pending & (r_pending - N_COMB'(1));
    end
endmodule

// File: tb/tb_pos_term_scanner.sv
// tb_pos_term_scanner: SETTLE=1 and SETTLE=3 scanners checked against a queue-based maxterm model
module tb_pos_term_scanner;
  logic clk = 0;
  logic rst_n = 0;
  logic st[2], rdy[2], fi[2];
  logic [15:0] fn[2];
  logic [3:0] drv[2], ti[2];
  logic bsy[2], dn[2], tv[2], tl[2];
  logic [15:0] tab[2];
  logic [4:0] zc[2];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int ph[2], mt[2], mn[2], mh[2], sc[2], mzo[2];
  int mq[2][16];
  bit [15:0] mf[2], mto[2];
  int lg[2][32], ln[2], lc[2], li[2], c4[2], tvc[2], dd[2];
  int dlog[2][64];

  always #5 clk = ~clk;

  assign fi[0] = fn[0][drv[0]];
  assign fi[1] = fn[1][drv[1]];

  pos_term_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .drv_abcd(drv[0]), .f_in(fi[0]),
    .busy(bsy[0]), .done(dn[0]), .table_out(tab[0]), .zero_cnt(zc[0]),
    .term_valid(tv[0]), .term_ready(rdy[0]), .term_idx(ti[0]), .term_last(tl[0]));
  pos_term_scanner #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .drv_abcd(drv[1]), .f_in(fi[1]),
    .busy(bsy[1]), .done(dn[1]), .table_out(tab[1]), .zero_cnt(zc[1]),
    .term_valid(tv[1]), .term_ready(rdy[1]), .term_idx(ti[1]), .term_last(tl[1]));

  function automatic int sv(input int k);
    return k == 0 ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: on accept, the maxterm list is the ascending set of zero entries of the emulated function
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0; mt[k] = 0; mn[k] = 0; mh[k] = 0; mto[k] = '0; mzo[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        case (ph[k])
          0: if (st[k]) begin
            ph[k] = 1; mt[k] = 0; mf[k] = fn[k]; mto[k] = '0; mzo[k] = 0; sc[k] = cyc;
            mn[k] = 0; mh[k] = 0;
            for (int i = 0; i < 16; i++) if (!fn[k][i]) begin mq[k][mn[k]] = i; mn[k]++; end
          end
          1: begin
            mt[k]++;
            if (mt[k] == 16 * sv(k)) begin ph[k] = 2; mto[k] = mf[k]; mzo[k] = mn[k]; end
          end
          2: if (mh[k] == mn[k]) ph[k] = 3;
             else if (rdy[k]) begin mh[k]++; if (mh[k] == mn[k]) ph[k] = 3; end
          default: ph[k] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n, ed;
      bit [15:0] et;
      bit ev;
      n = (ph[k] == 1) ? mt[k] / sv(k) : 0;
      et = (ph[k] == 1) ? (mf[k] & 16'((32'd1 << n) - 1)) : mto[k];
      ed = (ph[k] == 1) ? n - $countones(et) : mzo[k];
      ev = (ph[k] == 2) && (mh[k] < mn[k]);
      chk($sformatf("drv%0d", k), 32'(drv[k]), 32'((ph[k] == 1) ? n : (ph[k] == 0) ? 0 : 15));
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(ph[k] == 1 || ph[k] == 2));
      chk($sformatf("done%0d", k), 32'(dn[k]), 32'(ph[k] == 3));
      chk($sformatf("table%0d", k), 32'(tab[k]), 32'(et));
      chk($sformatf("zcnt%0d", k), 32'(zc[k]), 32'(ed));
      chk($sformatf("valid%0d", k), 32'(tv[k]), 32'(ev));
      if (ev) begin
        chk($sformatf("idx%0d", k), 32'(ti[k]), 32'(mq[k][mh[k]]));
        chk($sformatf("last%0d", k), 32'(tl[k]), 32'(mh[k] == mn[k] - 1));
      end else chk($sformatf("last%0d", k), 32'(tl[k]), 32'(0));
      if (bsy[k] && cyc - sc[k] < 64) dlog[k][cyc - sc[k]] = int'(drv[k]);
      if (tv[k]) tvc[k]++;
      if (tv[k] && ti[k] == 4'd4) c4[k]++;
      if (tv[k] && rdy[k] && ln[k] < 32) begin
        lg[k][ln[k]] = int'(ti[k]); ln[k]++;
        if (tl[k]) begin lc[k]++; li[k] = int'(ti[k]); end
      end
      if (dn[k]) dd[k] = cyc - sc[k];
    end
  end

  task automatic clr(input int k);
    ln[k] = 0; lc[k] = 0; li[k] = -1; c4[k] = 0; tvc[k] = 0; dd[k] = -1;
  endtask

  task automatic pulse(input int k);
    st[k] = 1;
    @(posedge clk); #2;
    st[k] = 0;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (!dn[k] && n < 300) begin @(posedge clk); #2; n++; end
    chk($sformatf("done seen%0d", k), 32'(dn[k]), 32'(1));
    @(posedge clk); #2;
  endtask

  task automatic chk_ref_seq(input int k, input string nm);
    int ref_q[8] = '{2, 3, 4, 7, 10, 11, 13, 15};
    chk({nm, " count"}, 32'(ln[k]), 32'(8));
    for (int i = 0; i < 8; i++) chk({nm, " seq"}, 32'(lg[k][i]), 32'(ref_q[i]));
    chk({nm, " last idx"}, 32'(li[k]), 32'(15));
    chk({nm, " last count"}, 32'(lc[k]), 32'(1));
  endtask

  initial begin
    int n;
    st[0] = 0; st[1] = 0; rdy[0] = 1; rdy[1] = 1;
    fn[0] = 16'h5363; fn[1] = 16'h5363;
    clr(0); clr(1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;
    chk("reset table", 32'(tab[0]), 32'(0));
    chk("reset busy", 32'(bsy[0]), 32'(0));

    clr(0); pulse(0); wait_done(0);
    chk("ref table", 32'(tab[0]), 32'h5363);
    chk("ref zcnt", 32'(zc[0]), 32'(8));
    chk("ref done latency", 32'(dd[0]), 32'(24));
    for (int i = 0; i < 16; i++) chk("ref drv step", 32'(dlog[0][i]), 32'(i));
    chk_ref_seq(0, "ref");

    fn[0] = 16'hFFFF; clr(0); pulse(0); wait_done(0);
    chk("one table", 32'(tab[0]), 32'hFFFF);
    chk("one zcnt", 32'(zc[0]), 32'(0));
    chk("one valid cycles", 32'(tvc[0]), 32'(0));
    chk("one done latency", 32'(dd[0]), 32'(17));

    fn[0] = 16'h0000; clr(0); pulse(0); wait_done(0);
    chk("zero table", 32'(tab[0]), 32'(0));
    chk("zero zcnt", 32'(zc[0]), 32'(16));
    chk("zero count", 32'(ln[0]), 32'(16));
    for (int i = 0; i < 16; i++) chk("zero seq", 32'(lg[0][i]), 32'(i));
    chk("zero last idx", 32'(li[0]), 32'(15));
    chk("zero last count", 32'(lc[0]), 32'(1));
    chk("zero done latency", 32'(dd[0]), 32'(32));

    fn[0] = 16'h5363; clr(0); pulse(0);
    n = 0;
    while (!(tv[0] && ti[0] == 4'd4) && n < 100) begin @(posedge clk); #2; n++; end
    chk("bp reach idx4", 32'(tv[0] && ti[0] == 4'd4), 32'(1));
    rdy[0] = 0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp hold valid", 32'(tv[0]), 32'(1));
      chk("bp hold idx", 32'(ti[0]), 32'(4));
    end
    rdy[0] = 1;
    wait_done(0);
    chk_ref_seq(0, "bp");
    chk("bp idx4 cycles", 32'(c4[0]), 32'(4));
    chk("bp done latency", 32'(dd[0]), 32'(27));

    clr(1); pulse(1);
    repeat (5) @(posedge clk);
    #2 pulse(1);
    chk("s3 busy mid", 32'(bsy[1]), 32'(1));
    wait_done(1);
    chk("s3 table", 32'(tab[1]), 32'h5363);
    chk("s3 zcnt", 32'(zc[1]), 32'(8));
    chk("s3 done latency", 32'(dd[1]), 32'(56));
    for (int i = 0; i < 48; i++) chk("s3 drv hold", 32'(dlog[1][i]), 32'(i / 3));
    chk_ref_seq(1, "s3");

    clr(0); pulse(0);
    n = 0;
    while (drv[0] != 4'd9 && n < 100) begin @(posedge clk); #2; n++; end
    chk("rst reach idx9", 32'(drv[0]), 32'(9));
    #1 rst_n = 0;
    #1;
    chk("rst drv", 32'(drv[0]), 32'(0));
    chk("rst busy", 32'(bsy[0]), 32'(0));
    chk("rst done", 32'(dn[0]), 32'(0));
    chk("rst table", 32'(tab[0]), 32'(0));
    chk("rst zcnt", 32'(zc[0]), 32'(0));
    chk("rst valid", 32'(tv[0]), 32'(0));
    chk("rst idx", 32'(ti[0]), 32'(0));
    chk("rst last", 32'(tl[0]), 32'(0));
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;
    clr(0); pulse(0); wait_done(0);
    chk("post-rst table", 32'(tab[0]), 32'h5363);
    chk("post-rst zcnt", 32'(zc[0]), 32'(8));
    chk("post-rst done latency", 32'(dd[0]), 32'(24));
    chk_ref_seq(0, "post-rst");

    repeat (2) @(posedge clk);
    #2 $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
